// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int BCD_W        = 4;
  localparam int BCD_MAX      = 9;
  localparam int SEC_TENS_MAX = 5;

  // Largest legal value of digit i; digit 1 holds tens of seconds in mm:ss mode.
  function automatic int digit_max(input int i, input int minsec);
    return (minsec == 1 && i == 1) ? SEC_TENS_MAX : BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with parallel load and a borrow chain.
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter int MAX = BCD_MAX
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] q,
  output logic             is_zero,
  output logic             borrow_out
);

  localparam logic [BCD_W-1:0] MAX_V = BCD_W'(MAX);

  logic [BCD_W-1:0] r_q;

  // Digit register: load wins; a borrow at 0 wraps to MAX, otherwise decrements.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q <= '0;
    end else if (ld) begin
      r_q <= ld_val;
    end else if (borrow_in) begin
      r_q <= is_zero ? MAX_V : r_q - BCD_W'(1);
    end
  end

  assign q          = r_q;
  assign is_zero    = (r_q == '0);
  assign borrow_out = borrow_in & is_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with run/pause/done control and load clamping.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int MINSEC = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  running,
  output logic                  done,
  output logic                  load_err
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_load_err;
  logic [DIGITS:0]       w_borrow;
  logic [DIGITS-1:0]     w_digit_zero;
  logic [DIGITS-1:0]     w_clamped;
  logic [4*DIGITS-1:0]   w_clamp_val;
  logic [4*DIGITS-1:0]   w_ld_val;
  logic [4*DIGITS-1:0]   w_count;
  logic                  w_ld;
  logic                  w_dec;
  logic                  w_cancel;
  logic                  w_zero;
  logic                  w_last_sec;
  logic                  w_unused_borrow;

  // Digit chain: each digit clamps its own load value and passes borrow upward.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    localparam int               MAXD = digit_max(g, MINSEC);
    localparam logic [BCD_W-1:0] MAXV = BCD_W'(MAXD);

    assign w_clamped[g]            = (data[4*g +: 4] > MAXV);
    assign w_clamp_val[4*g +: 4]   = w_clamped[g] ? MAXV : data[4*g +: 4];

    bcd_digit_down #(.MAX(MAXD)) u_digit (
      .clk        (clk),
      .clr        (clr),
      .ld         (w_ld),
      .ld_val     (w_ld_val[4*g +: 4]),
      .borrow_in  (w_borrow[g]),
      .q          (w_count[4*g +: 4]),
      .is_zero    (w_digit_zero[g]),
      .borrow_out (w_borrow[g+1])
    );
  end

  // Borrow out of the top digit cannot occur because a zero count is never decremented.
  assign w_unused_borrow = w_borrow[DIGITS];
  assign w_borrow[0]     = w_dec;
  assign w_zero          = &w_digit_zero;
  assign w_last_sec      = (w_count == (4*DIGITS)'(1));
  assign w_ld            = load | w_cancel;
  assign w_ld_val        = w_cancel ? '0 : w_clamp_val;

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: load > stop > start > tick, only the top active request acts.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_dec       = 1'b0;
    w_cancel    = 1'b0;
    if (load) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!stop && start && !w_zero) w_state_nxt = RUNNING;
        end
        RUNNING: begin
          if (stop) begin
            w_state_nxt = PAUSED;
          end else if (!start && tick && !w_zero) begin
            w_dec = 1'b1;
            if (w_last_sec) w_state_nxt = DONE;
          end
        end
        PAUSED: begin
          if (stop) begin
            w_state_nxt = IDLE;
            w_cancel    = 1'b1;
          end else if (start && !w_zero) begin
            w_state_nxt = RUNNING;
          end
        end
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Load-error pulse, registered so it lines up with the loaded count.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= load & (|w_clamped);
    end
  end

  assign count    = w_count;
  assign zero     = w_zero;
  assign running  = (r_state == RUNNING);
  assign done     = (r_state == DONE);
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer (DIGITS=4, MINSEC=1 and MINSEC=0).
module tb_bcd_countdown_timer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         clr;
  logic         load, start, stop, tick;
  logic [W-1:0] data;
  logic [W-1:0] count;
  logic         zero, running, done, load_err;

  logic         b_load, b_start, b_stop, b_tick;
  logic [W-1:0] b_data, b_count;
  logic         b_zero, b_running, b_done, b_load_err;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: count held as a plain number of seconds (mixed radix).
  int m_val;
  int m_st;
  bit m_err;

  bcd_countdown_timer #(.DIGITS(DIGITS), .MINSEC(1)) u_dut (
    .clk(clk), .clr(clr), .load(load), .data(data), .start(start), .stop(stop),
    .tick(tick), .count(count), .zero(zero), .running(running), .done(done),
    .load_err(load_err)
  );

  bcd_countdown_timer #(.DIGITS(DIGITS), .MINSEC(0)) u_dut_dec (
    .clk(clk), .clr(clr), .load(b_load), .data(b_data), .start(b_start), .stop(b_stop),
    .tick(b_tick), .count(b_count), .zero(b_zero), .running(b_running), .done(b_done),
    .load_err(b_load_err)
  );

  always #5 clk = ~clk;

  function automatic int radix(input int i);
    return (i == 1) ? 6 : 10;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % radix(i));
      v = v / radix(i);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0;
    m_st  = M_IDLE;
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic ld, input logic [W-1:0] d,
                            input logic sa, input logic so, input logic tk);
    int v;
    int dig;
    m_err = 1'b0;
    if (ld) begin
      v = 0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        dig = int'(d[4*i +: 4]);
        if (dig > radix(i) - 1) begin
          dig   = radix(i) - 1;
          m_err = 1'b1;
        end
        v = v * radix(i) + dig;
      end
      m_val = v;
      m_st  = M_IDLE;
    end else if (m_st == M_DONE) begin
      m_st = M_IDLE;
    end else if (so) begin
      if (m_st == M_RUN) begin
        m_st = M_PAUSE;
      end else if (m_st == M_PAUSE) begin
        m_st  = M_IDLE;
        m_val = 0;
      end
    end else if (sa) begin
      if ((m_st == M_IDLE || m_st == M_PAUSE) && m_val != 0) m_st = M_RUN;
    end else if (tk && m_st == M_RUN && m_val != 0) begin
      m_val--;
      if (m_val == 0) m_st = M_DONE;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},    32'(count),    32'(to_bcd(m_val)));
    check({tag, ".zero"},     32'(zero),     32'(m_val == 0));
    check({tag, ".running"},  32'(running),  32'(m_st == M_RUN));
    check({tag, ".done"},     32'(done),     32'(m_st == M_DONE));
    check({tag, ".load_err"}, 32'(load_err), 32'(m_err));
  endtask

  // One clock with the given requests held across the edge, then model and compare.
  task automatic cycle(input string tag, input logic ld, input logic [W-1:0] d,
                       input logic sa, input logic so, input logic tk);
    load = ld; data = d; start = sa; stop = so; tick = tk;
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    model_step(ld, d, sa, so, tk);
    check_all(tag);
  endtask

  initial begin
    logic         r_ld;
    logic [W-1:0] r_d;

    clr = 1'b1;
    load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0; data = '0;
    b_load = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_tick = 1'b0; b_data = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    clr = 1'b0;

    // Basic decrement across the seconds/minutes boundary.
    cycle("basic.load",  1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    cycle("basic.start", 1'b0, '0,       1'b1, 1'b0, 1'b0);
    cycle("basic.tick",  1'b0, '0,       1'b0, 1'b0, 1'b1);
    check("basic.0059", 32'(count), 32'h0059);

    // Expiry: done pulse for one cycle, then idle, further ticks ignored.
    cycle("exp.load",  1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    cycle("exp.start", 1'b0, '0,       1'b1, 1'b0, 1'b0);
    cycle("exp.tick1", 1'b0, '0,       1'b0, 1'b0, 1'b1);
    cycle("exp.tick2", 1'b0, '0,       1'b0, 1'b0, 1'b1);
    check("exp.done_pulse", 32'({done, count}), 32'({1'b1, 16'h0000}));
    cycle("exp.after", 1'b0, '0,       1'b0, 1'b0, 1'b0);
    check("exp.done_gone", 32'(done), 32'd0);
    cycle("exp.tick3", 1'b0, '0,       1'b0, 1'b0, 1'b1);

    // Clamping of out-of-range digits.
    cycle("clamp.load",  1'b1, 16'h0A7C, 1'b0, 1'b0, 1'b0);
    check("clamp.0959", 32'({load_err, count}), 32'({1'b1, 16'h0959}));
    cycle("clamp.start", 1'b0, '0,       1'b1, 1'b0, 1'b0);
    cycle("clamp.tick",  1'b0, '0,       1'b0, 1'b0, 1'b1);
    check("clamp.0958", 32'(count), 32'h0958);

    // Pause, resume, cancel.
    cycle("pause.load",   1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
    cycle("pause.start",  1'b0, '0,       1'b1, 1'b0, 1'b0);
    cycle("pause.tick",   1'b0, '0,       1'b0, 1'b0, 1'b1);
    cycle("pause.stop",   1'b0, '0,       1'b0, 1'b1, 1'b0);
    cycle("pause.tickA",  1'b0, '0,       1'b0, 1'b0, 1'b1);
    cycle("pause.tickB",  1'b0, '0,       1'b0, 1'b0, 1'b1);
    check("pause.0029", 32'(count), 32'h0029);
    cycle("pause.resume", 1'b0, '0,       1'b1, 1'b0, 1'b0);
    cycle("pause.tickC",  1'b0, '0,       1'b0, 1'b0, 1'b1);
    check("pause.0028", 32'(count), 32'h0028);
    cycle("pause.stop1",  1'b0, '0,       1'b0, 1'b1, 1'b0);
    cycle("pause.stop2",  1'b0, '0,       1'b0, 1'b1, 1'b0);
    check("pause.cancel", 32'({running, count}), 32'd0);

    // Simultaneous requests.
    cycle("sim.load",      1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    cycle("sim.start",     1'b0, '0,       1'b1, 1'b0, 1'b0);
    cycle("sim.stop_tick", 1'b0, '0,       1'b0, 1'b1, 1'b1);
    check("sim.0010", 32'(count), 32'h0010);
    cycle("sim.reload",    1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    cycle("sim.start_tick",1'b0, '0,       1'b1, 1'b0, 1'b1);
    check("sim.no_dec", 32'({running, count}), 32'({1'b1, 16'h0010}));
    cycle("sim.load_stop", 1'b1, 16'h0005, 1'b0, 1'b1, 1'b0);
    check("sim.0005", 32'({running, count}), 32'({1'b0, 16'h0005}));
    cycle("sim.load0",     1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle("sim.start0",    1'b0, '0,       1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a run.
    cycle("arst.load",  1'b1, 16'h0512, 1'b0, 1'b0, 1'b0);
    cycle("arst.start", 1'b0, '0,       1'b1, 1'b0, 1'b0);
    #2;
    clr = 1'b1;
    #1;
    model_reset();
    check_all("arst.mid");
    @(negedge clk);
    clr = 1'b0;
    for (int n = 0; n < 3; n++) cycle("arst.after", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r_ld = ($urandom_range(0, 15) == 0);
      r_d  = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 255));
      cycle("rand", r_ld, r_d, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0);
    end

    // Plain decimal variant: 1000 -> 0999.
    b_load = 1'b1; b_data = 16'h1000;
    @(posedge clk); #1;
    b_load = 1'b0;
    check("dec.load", 32'({b_load_err, b_count}), 32'({1'b0, 16'h1000}));
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    check("dec.running", 32'(b_running), 32'd1);
    b_tick = 1'b1;
    @(posedge clk); #1;
    b_tick = 1'b0;
    check("dec.0999", 32'({b_done, b_count}), 32'({1'b0, 16'h0999}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
